// File: rtl/edubos5_rf_wr_ctrl.sv
// Write-side controller for the eduBOS5 register file: post-reset clear sequencer,
// CPU writeback / debug write arbitration with starvation preemption, and x0 protection.
module edubos5_rf_wr_ctrl #(
  parameter int unsigned NREGS      = 32,
  parameter logic [31:0] INIT_VAL   = 32'h0,
  parameter int unsigned STARVE_MAX = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_we,
  input  logic [4:0]  cpu_addr,
  input  logic [31:0] cpu_wdat,
  output logic        cpu_stall,
  output logic        init_done,
  input  logic        dbg_req,
  input  logic [4:0]  dbg_addr,
  input  logic [31:0] dbg_wdat,
  output logic        dbg_ack,
  output logic [4:0]  rf_addr,
  output logic        rf_we,
  output logic [31:0] rf_wdat
);

  localparam int unsigned CW = $clog2(NREGS);
  localparam logic [CW-1:0] LastIdx = CW'(NREGS - 1);
  localparam logic [7:0] StarveMax = 8'(STARVE_MAX);

  typedef enum logic {StInit, StRun} state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  clr_cnt_q, clr_cnt_d;
  logic [7:0]     wait_cnt_q, wait_cnt_d;
  logic           sel_dbg;
  logic           served;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StInit;
      clr_cnt_q  <= '0;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    clr_cnt_d  = clr_cnt_q;
    wait_cnt_d = wait_cnt_q;
    rf_we      = 1'b0;
    rf_addr    = '0;
    rf_wdat    = '0;
    cpu_stall  = 1'b1;
    init_done  = 1'b0;
    dbg_ack    = 1'b0;
    sel_dbg    = 1'b0;
    served     = 1'b0;

    // Outputs stay in their quiet reset values whenever rst_n is low.
    if (rst_n) begin
      case (state_q)
        StInit: begin
          rf_we      = 1'b1;
          rf_addr    = 5'(clr_cnt_q);
          rf_wdat    = (clr_cnt_q == '0) ? 32'h0 : INIT_VAL;
          clr_cnt_d  = clr_cnt_q + 1'b1;
          wait_cnt_d = '0;
          if (clr_cnt_q == LastIdx) begin
            state_d = StRun;
          end
        end
        StRun: begin
          init_done = 1'b1;
          cpu_stall = 1'b0;
          rf_addr   = cpu_addr;
          rf_wdat   = cpu_wdat;
          if (dbg_req && (wait_cnt_q == StarveMax)) begin
            // Starved debug preempts the CPU for one cycle.
            sel_dbg   = 1'b1;
            served    = 1'b1;
            cpu_stall = 1'b1;
          end else if (cpu_we) begin
            served = 1'b1;
          end else if (dbg_req) begin
            sel_dbg = 1'b1;
            served  = 1'b1;
          end
          if (sel_dbg) begin
            rf_addr = dbg_addr;
            rf_wdat = dbg_wdat;
            dbg_ack = 1'b1;
          end
          // x0 is hardwired zero: the source is acknowledged but nothing is written.
          rf_we = served && (rf_addr != 5'd0);
          if (dbg_ack || !dbg_req) begin
            wait_cnt_d = '0;
          end else if (wait_cnt_q < StarveMax) begin
            wait_cnt_d = wait_cnt_q + 8'd1;
          end
        end
        default: state_d = StInit;
      endcase
    end
  end

endmodule

// File: tb/tb_edubos5_rf_wr_ctrl.sv
// Scoreboard bench for edubos5_rf_wr_ctrl: stimulus pushes per-cycle expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_edubos5_rf_wr_ctrl;

  localparam logic [31:0] InitVal = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_we;
  logic [4:0]  cpu_addr;
  logic [31:0] cpu_wdat;
  logic        cpu_stall;
  logic        init_done;
  logic        dbg_req;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_wdat;
  logic        dbg_ack;
  logic [4:0]  rf_addr;
  logic        rf_we;
  logic [31:0] rf_wdat;

  typedef struct packed {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wdat;
    logic        ack;
    logic        stall;
    logic        done;
  } exp_t;

  exp_t  exp_q[$];
  string nm_q[$];
  int    n_chk  = 0;
  int    n_pass = 0;

  edubos5_rf_wr_ctrl #(
    .NREGS     (32),
    .INIT_VAL  (InitVal),
    .STARVE_MAX(15)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cpu_we   (cpu_we),
    .cpu_addr (cpu_addr),
    .cpu_wdat (cpu_wdat),
    .cpu_stall(cpu_stall),
    .init_done(init_done),
    .dbg_req  (dbg_req),
    .dbg_addr (dbg_addr),
    .dbg_wdat (dbg_wdat),
    .dbg_ack  (dbg_ack),
    .rf_addr  (rf_addr),
    .rf_we    (rf_we),
    .rf_wdat  (rf_wdat)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic we, input logic [4:0] a, input logic [31:0] d,
                              input logic ack, input logic st, input logic dn);
    exp_t e;
    e.we = we; e.addr = a; e.wdat = d; e.ack = ack; e.stall = st; e.done = dn;
    return e;
  endfunction

  // Monitor: outputs are combinational, so every cycle with a queued expectation is checked.
  always @(negedge clk) begin
    exp_t  e;
    exp_t  act;
    string nm;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      nm  = nm_q.pop_front();
      act = {rf_we, rf_addr, rf_wdat, dbg_ack, cpu_stall, init_done};
      n_chk++;
      if (act === e) begin
        n_pass++;
      end else begin
        $display("FAIL %s: got we=%b addr=%0d wdat=%h ack=%b stall=%b done=%b, want we=%b addr=%0d wdat=%h ack=%b stall=%b done=%b",
                 nm, act.we, act.addr, act.wdat, act.ack, act.stall, act.done,
                 e.we, e.addr, e.wdat, e.ack, e.stall, e.done);
      end
    end
  end

  task automatic chk(input string nm, input exp_t e);
    exp_q.push_back(e);
    nm_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  task automatic clear_seq(input string tag, input int ncyc);
    for (int i = 0; i < ncyc; i++) begin
      chk($sformatf("%s_clr%0d", tag, i),
          mk(1'b1, 5'(i), (i == 0) ? 32'h0 : InitVal, 1'b0, 1'b1, 1'b0));
    end
  endtask

  // CPU writes x5 continuously while debug targets x9: 15 CPU writes, preempt, resume.
  task automatic starve(input string tag);
    cpu_we = 1'b1; cpu_addr = 5'd5; cpu_wdat = 32'h0BAD_0005;
    dbg_req = 1'b1; dbg_addr = 5'd9; dbg_wdat = 32'h9999_0009;
    for (int i = 0; i < 15; i++) begin
      chk($sformatf("%s_cpu%0d", tag, i), mk(1'b1, 5'd5, 32'h0BAD_0005, 1'b0, 1'b0, 1'b1));
    end
    chk({tag, "_preempt"}, mk(1'b1, 5'd9, 32'h9999_0009, 1'b1, 1'b1, 1'b1));
    dbg_req = 1'b0;
    chk({tag, "_resume"}, mk(1'b1, 5'd5, 32'h0BAD_0005, 1'b0, 1'b0, 1'b1));
  endtask

  initial begin
    exp_t rst_e;
    rst_e = mk(1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 1'b0);

    rst_n = 1'b0; cpu_we = 1'b1; cpu_addr = 5'd3; cpu_wdat = 32'h0000_1111;
    dbg_req = 1'b1; dbg_addr = 5'd4; dbg_wdat = 32'h0000_2222;
    @(posedge clk);
    #1;

    for (int i = 0; i < 3; i++) chk($sformatf("reset%0d", i), rst_e);

    // Requests during the clear sequence must be ignored.
    rst_n = 1'b1;
    clear_seq("boot", 32);

    cpu_we = 1'b0; dbg_req = 1'b0; cpu_addr = 5'd3; cpu_wdat = 32'h0000_0011;
    chk("run_idle", mk(1'b0, 5'd3, 32'h0000_0011, 1'b0, 1'b0, 1'b1));

    cpu_we = 1'b1; cpu_addr = 5'd5; cpu_wdat = 32'h1234_5678;
    chk("cpu_wr_x5", mk(1'b1, 5'd5, 32'h1234_5678, 1'b0, 1'b0, 1'b1));
    cpu_addr = 5'd0;
    chk("cpu_wr_x0", mk(1'b0, 5'd0, 32'h1234_5678, 1'b0, 1'b0, 1'b1));

    cpu_we = 1'b0; dbg_req = 1'b1; dbg_addr = 5'd7; dbg_wdat = 32'hA5A5_A5A5;
    chk("dbg_idle_x7", mk(1'b1, 5'd7, 32'hA5A5_A5A5, 1'b1, 1'b0, 1'b1));
    dbg_req = 1'b0;
    chk("dbg_dropped", mk(1'b0, 5'd0, 32'h1234_5678, 1'b0, 1'b0, 1'b1));
    dbg_req = 1'b1; dbg_addr = 5'd0; dbg_wdat = 32'hCAFE_F00D;
    chk("dbg_x0", mk(1'b0, 5'd0, 32'hCAFE_F00D, 1'b1, 1'b0, 1'b1));

    starve("starve");

    rst_n = 1'b0;
    chk("rst_again", rst_e);
    rst_n = 1'b1;
    clear_seq("part", 10);
    rst_n = 1'b0;
    chk("rst_mid_init", rst_e);
    rst_n = 1'b1;
    clear_seq("restart", 32);
    cpu_we = 1'b1; cpu_addr = 5'd12; cpu_wdat = 32'h0C0C_0C0C; dbg_req = 1'b0;
    chk("run_after_restart", mk(1'b1, 5'd12, 32'h0C0C_0C0C, 1'b0, 1'b0, 1'b1));

    // Build up wait_cnt, then reset: the pending request must be dropped.
    cpu_addr = 5'd5; cpu_wdat = 32'h0BAD_0005;
    dbg_req = 1'b1; dbg_addr = 5'd9; dbg_wdat = 32'h9999_0009;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("pend_cpu%0d", i), mk(1'b1, 5'd5, 32'h0BAD_0005, 1'b0, 1'b0, 1'b1));
    end
    rst_n = 1'b0;
    chk("rst_pend0", rst_e);
    chk("rst_pend1", rst_e);
    rst_n = 1'b1; dbg_req = 1'b0;
    clear_seq("pend", 32);
    // Full 16-cycle latency again shows wait_cnt restarted from zero.
    starve("restarve");

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_chk++;
      $display("FAIL scoreboard_drain: got %0d leftover entries, want 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion (%0d/%0d so far)", n_pass, n_chk);
    $fatal(1);
  end

endmodule

// File: doc/edubos5_rf_wr_ctrl.md
# edubos5_rf_wr_ctrl

Write-side controller for the eduBOS5 register file (1 sync write + 2 async read ports, no reset on storage). It produces the RF write port (address, enable, data) by arbitrating among a post-reset clear sequencer, CPU writeback and a debug write port. It also enforces x0 = 0 and stalls the CPU until the RF holds known values. It sits between the CPU writeback stage / debug module and the RF write port.

## Interface
Parameters:
- NREGS, 32, number of RF entries; must be a power of 2 matching the RF depth.
- INIT_VAL, 32'h0, value written to x1..x(NREGS-1) during the clear sequence; x0 always gets 0.
- STARVE_MAX, 15, cycles a pending debug request may wait before it preempts the CPU; range 1..255.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- cpu_we  in  1  CPU writeback write enable.
- cpu_addr  in  5  CPU writeback register index.
- cpu_wdat  in  32 (cpu_data_t)  CPU writeback data.
- cpu_stall  out  1  high means the CPU must hold its pipeline and its writeback (cpu_we/addr/wdat stable).
- init_done  out  1  high once the clear sequence has completed.
- dbg_req  in  1  debug write request; dbg_addr and dbg_wdat stable while high.
- dbg_addr  in  5  debug target register.
- dbg_wdat  in  32  debug write data.
- dbg_ack  out  1  single-cycle pulse in the cycle the debug write is issued.
- rf_addr  out  5  to RF write address.
- rf_we  out  1  to RF write enable.
- rf_wdat  out  32  to RF write data.

## Operation
- State: FSM {INIT, RUN}, clear counter clr_cnt [log2(NREGS)], starvation counter wait_cnt [8].
- Reset (rst_n=0 at an edge): state=INIT, clr_cnt=0, wait_cnt=0. While rst_n is low, the outputs are rf_we=0, cpu_stall=1, init_done=0, dbg_ack=0, rf_addr=0, rf_wdat=0.
- INIT: each cycle rf_we=1, rf_addr=clr_cnt, rf_wdat = (clr_cnt==0) ? 0 : INIT_VAL. cpu_stall=1, dbg_ack=0, and cpu_we and dbg_req are ignored. clr_cnt increments. When clr_cnt==NREGS-1, the next state is RUN.
- RUN: init_done=1. The source is selected combinationally in priority order:
  1. Starved debug: dbg_req=1 and wait_cnt==STARVE_MAX → cpu_stall=1, the debug write is issued, dbg_ack=1.
  2. CPU: cpu_we=1 → the CPU write is issued, cpu_stall=0.
  3. Debug: dbg_req=1 and cpu_we=0 → the debug write is issued, dbg_ack=1.
  4. Otherwise rf_we=0 and rf_addr/rf_wdat follow cpu_addr/cpu_wdat.
- x0 protection in RUN: if the selected address is 0, rf_we is forced to 0. The source is still considered served, so dbg_ack still pulses.
- wait_cnt: cleared on dbg_ack or when dbg_req=0. It increments, saturating at STARVE_MAX, in each RUN cycle where dbg_req=1 and no ack is given.
- Debug handshake: the requester drops dbg_req in the cycle after dbg_ack. If dbg_req is still high after the ack, it is treated as a new request.
- cpu_stall is 0 in RUN except in the preemption cycle.

## Timing
- Outputs rf_* / dbg_ack / cpu_stall are combinational from state plus inputs. There are zero cycles of write latency: the RF samples the write at the same edge.
- Clear sequence: with rst_n released before edge E0, the edges E0..E(NREGS-1) write x0..x(NREGS-1). init_done=1 and cpu_stall=0 from the cycle after E(NREGS-1). Total NREGS cycles.
- Reset mid-INIT restarts from clr_cnt=0. Reset in RUN with a debug request pending drops it: no ack, wait_cnt=0, and the requester must re-request after init_done.
- Debug worst-case latency under continuous cpu_we: ack in the STARVE_MAX+1-th cycle of the request.
- A simultaneous cpu_we and non-starved dbg_req means the CPU wins; the debug request waits and wait_cnt increments.

## Test plan
- Reset/clear: hold rst_n=0 3 cycles, then release with INIT_VAL=32'hDEAD_BEEF → rf_we=1 for 32 cycles, addr 0..31, x0 written 0, x1..x31 = DEADBEEF; init_done rises after 32 cycles; cpu_stall=1 throughout, then 0.
- CPU writes: cpu_we=1, addr=5, wdat=32'h1234_5678 → rf_we=1, rf_addr=5, same data, same cycle; addr=0 → rf_we=0.
- Debug idle path: cpu_we=0, dbg_req=1, addr=7, wdat=32'hA5A5_A5A5 → dbg_ack and rf_we in the same cycle, x7 written; x0 target → dbg_ack=1, rf_we=0.
- Starvation: cpu_we=1 continuously, dbg_req=1 (addr 9), STARVE_MAX=15 → 15 CPU writes, then in cycle 16 cpu_stall=1, dbg_ack=1, rf_addr=9; next cycle the CPU write resumes with held data.
- Reset mid-operation: assert rst_n=0 at clear-sequence cycle 10, release → sequence restarts at addr 0 and lasts a full 32 cycles. Reset during a pending debug request → no dbg_ack, wait_cnt=0.
